lcd_frame_engine: RTL and testbench



---
 rtl/lcd_frame_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_lcd_frame_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : lcd_frame_engine
// Description : Composes the two 16-character LCD rows for the memory game
//               and hands completed frames to the LCD driver over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_frame_engine #(
    parameter int SCORE_W    = 16,
    parameter int DIGITS     = 5,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCROLL_DIV = 12500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         state,
    input  logic [3:0]         current_round,
    input  logic [SCORE_W-1:0] total_score,
    output logic [127:0]       line_1,
    output logic [127:0]       line_2,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               bcd_busy
);

    // The shift register holds every digit the binary width can produce, plus
    // at least one digit above the displayed ones so overflow is detectable.
    localparam int c_BCD_RAW  = SCORE_W * 3 / 10 + 2;
    localparam int c_BCD_N    = (c_BCD_RAW > DIGITS) ? c_BCD_RAW : DIGITS + 1;
    localparam int c_ITER_W   = $clog2(SCORE_W + 1);
    localparam int c_BLINK_W  = $clog2(BLINK_DIV + 1);
    localparam int c_SCROLL_W = $clog2(SCROLL_DIV + 1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PASS = 3'd5;
    localparam logic [2:0] c_ST_FAIL = 3'd6;
    localparam logic [2:0] c_ST_DONE = 3'd7;

    localparam logic [127:0] c_BLANK      = {16{8'h20}};
    localparam logic [127:0] c_GAME_START = "   Game Start   ";
    localparam logic [127:0] c_PRESS      = "Press Start     ";
    localparam logic [127:0] c_SUCCESS    = "    Success!    ";
    localparam logic [127:0] c_NEXT       = " Next Level...  ";
    localparam logic [127:0] c_FAIL_TXT   = "     Fail...    ";
    localparam logic [127:0] c_TRY        = "  Try Again...  ";
    localparam logic [127:0] c_FINAL      = "  FINAL SCORE   ";
    localparam logic [55:0]  c_SCORE_PFX  = "Score: ";
    localparam logic [55:0]  c_TOTAL_PFX  = "Total: ";

    logic                   r_busy;
    logic [c_ITER_W-1:0]    r_iter;
    logic [SCORE_W-1:0]     r_bin;
    logic [SCORE_W-1:0]     r_sample;
    logic [SCORE_W-1:0]     r_last;
    logic [4*c_BCD_N-1:0]   r_bcd_sh;
    logic [4*DIGITS-1:0]    r_score_bcd;
    logic [c_BLINK_W-1:0]   r_blink_cnt;
    logic                   r_blink_vis;
    logic [c_SCROLL_W-1:0]  r_scroll_cnt;
    logic [3:0]             r_offset;
    logic [2:0]             r_state_q;
    logic [127:0]           r_line_1;
    logic [127:0]           r_line_2;
    logic                   r_valid;

    logic [4*c_BCD_N-1:0]   w_adj;
    logic [4*c_BCD_N:0]     w_shift;
    logic                   w_sat;
    logic [4*DIGITS-1:0]    w_bcd_store;
    logic                   w_state_chg;
    logic                   w_visible;
    logic [3:0]             w_offset;
    logic [7:0]             w_tens;
    logic [7:0]             w_ones;
    logic [255:0]           w_rot;
    logic [127:0]           w_lv_line;
    logic [127:0]           w_num_line;
    logic [127:0]           w_tot_line;
    logic [127:0]           w_comp_1;
    logic [127:0]           w_comp_2;
    logic                   w_changed;

    assign line_1      = r_line_1;
    assign line_2      = r_line_2;
    assign frame_valid = r_valid;
    assign bcd_busy    = r_busy;

    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < c_BCD_N; i++) begin
            w_adj[4*i +: 4] = (r_bcd_sh[4*i +: 4] >= 4'd5) ? r_bcd_sh[4*i +: 4] + 4'd3
                                                         : r_bcd_sh[4*i +: 4];
        end
        w_shift     = {w_adj, r_bin[SCORE_W-1]};
        w_sat       = |w_shift[4*c_BCD_N:4*DIGITS];
        w_bcd_store = w_sat ? {DIGITS{4'h9}} : w_shift[4*DIGITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_iter      <= '0;
            r_bin       <= '0;
            r_sample    <= '0;
            r_last      <= '0;
            r_bcd_sh    <= '0;
            r_score_bcd <= '0;
        end else if (r_busy) begin
            r_bcd_sh <= w_shift[4*c_BCD_N-1:0];
            r_bin    <= r_bin << 1;
            r_iter   <= r_iter + 1'b1;
            if (r_iter == c_ITER_W'(SCORE_W - 1)) begin
                r_score_bcd <= w_bcd_store;
                r_last      <= r_sample;
                r_busy      <= 1'b0;
            end
        end else if (total_score != r_last) begin
            r_busy   <= 1'b1;
            r_sample <= total_score;
            r_bin    <= total_score;
            r_bcd_sh <= '0;
            r_iter   <= '0;
        end
    end

    assign w_state_chg = (state != r_state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_IDLE;
            r_blink_cnt  <= '0;
            r_blink_vis  <= 1'b1;
            r_scroll_cnt <= '0;
            r_offset     <= '0;
        end else begin
            r_state_q <= state;
            if (w_state_chg) begin
                r_blink_cnt  <= '0;
                r_blink_vis  <= 1'b1;
                r_scroll_cnt <= '0;
                r_offset     <= '0;
            end else begin
                if (r_blink_cnt == c_BLINK_W'(BLINK_DIV - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink_vis <= ~r_blink_vis;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
                if (r_scroll_cnt == c_SCROLL_W'(SCROLL_DIV - 1)) begin
                    r_scroll_cnt <= '0;
                    r_offset     <= r_offset + 4'd1;
                end else begin
                    r_scroll_cnt <= r_scroll_cnt + 1'b1;
                end
            end
        end
    end

    // On the entry edge the counters are about to clear, so compose with the
    // restarted phase/offset rather than the stale registered ones.
    always_comb begin
        w_visible = r_blink_vis | w_state_chg;
        w_offset  = w_state_chg ? 4'd0 : r_offset;
        w_tens    = (current_round >= 4'd10) ? 8'h31 : 8'h30;
        w_ones    = 8'h30 + {4'h0, (current_round >= 4'd10) ? current_round - 4'd10
                                                              : current_round};
        w_rot     = {c_PRESS, c_PRESS} << {w_offset, 3'b000};
        w_lv_line = {"Lv. ", w_tens, w_ones, {10{8'h20}}};

        w_num_line = c_BLANK;
        w_tot_line = c_BLANK;
        for (int i = 0; i < 7; i++) begin
            w_num_line[127-8*i -: 8] = c_SCORE_PFX[55-8*i -: 8];
            w_tot_line[127-8*i -: 8] = c_TOTAL_PFX[55-8*i -: 8];
        end
        for (int d = 0; d < DIGITS; d++) begin
            w_num_line[127-8*(7+d) -: 8] = 8'h30 + {4'h0, r_score_bcd[4*(DIGITS-1-d) +: 4]};
            w_tot_line[127-8*(7+d) -: 8] = 8'h30 + {4'h0, r_score_bcd[4*(DIGITS-1-d) +: 4]};
        end

        w_comp_1 = w_lv_line;
        w_comp_2 = w_num_line;
        case (state)
            c_ST_IDLE: begin
                w_comp_1 = c_GAME_START;
                w_comp_2 = w_rot[255:128];
            end
            c_ST_PASS: begin
                w_comp_1 = w_visible ? c_SUCCESS : c_BLANK;
                w_comp_2 = c_NEXT;
            end
            c_ST_FAIL: begin
                w_comp_1 = w_visible ? c_FAIL_TXT : c_BLANK;
                w_comp_2 = c_TRY;
            end
            c_ST_DONE: begin
                w_comp_1 = c_FINAL;
                w_comp_2 = w_tot_line;
            end
            default: begin
                w_comp_1 = w_lv_line;
                w_comp_2 = w_num_line;
            end
        endcase
    end

    assign w_changed = (w_comp_1 != r_line_1) || (w_comp_2 != r_line_2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_1 <= c_BLANK;
            r_line_2 <= c_BLANK;
            r_valid  <= 1'b0;
        end else if (w_changed && (!r_valid || frame_ready)) begin
            r_line_1 <= w_comp_1;
            r_line_2 <= w_comp_2;
            r_valid  <= 1'b1;
        end else if (r_valid && frame_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_frame_engine
// Description : Self-checking bench for lcd_frame_engine (DIGITS=5 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_frame_engine;

    localparam logic [127:0] c_BLANK = {16{8'h20}};

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   state;
    logic [3:0]   current_round;
    logic [15:0]  total_score;
    logic         frame_ready;
    logic [127:0] line_1, line_2, line_1_d4, line_2_d4;
    logic         frame_valid, frame_valid_d4, bcd_busy, bcd_busy_d4;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0]   st;
        logic [3:0]   rnd;
        logic [15:0]  score;
        logic [127:0] l1;
        logic [127:0] l2;
        logic [127:0] l2d4;
    } vec_t;

    vec_t vecs[9];
    vec_t sb_q[$];
    vec_t exp_v;

    always #5 clk = ~clk;

    lcd_frame_engine #(.SCORE_W(16), .DIGITS(5), .BLINK_DIV(4), .SCROLL_DIV(3)) dut (
        .clk(clk), .rst(rst), .state(state), .current_round(current_round),
        .total_score(total_score), .line_1(line_1), .line_2(line_2),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .bcd_busy(bcd_busy)
    );

    lcd_frame_engine #(.SCORE_W(16), .DIGITS(4), .BLINK_DIV(4), .SCROLL_DIV(3)) dut_d4 (
        .clk(clk), .rst(rst), .state(state), .current_round(current_round),
        .total_score(total_score), .line_1(line_1_d4), .line_2(line_2_d4),
        .frame_valid(frame_valid_d4), .frame_ready(frame_ready), .bcd_busy(bcd_busy_d4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_line(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Counts the cycles bcd_busy stays high from the current sample onward.
    task automatic busy_len(output int n);
        n = 0;
        while (bcd_busy && n < 64) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  n;
        int  bad;

        vecs[0] = '{3'd3, 4'd7,  16'd0,     "Lv. 07          ", "Score: 00000    ", "Score: 0000     "};
        vecs[1] = '{3'd3, 4'd7,  16'd1234,  "Lv. 07          ", "Score: 01234    ", "Score: 1234     "};
        vecs[2] = '{3'd1, 4'd12, 16'd1234,  "Lv. 12          ", "Score: 01234    ", "Score: 1234     "};
        vecs[3] = '{3'd5, 4'd12, 16'd1234,  "    Success!    ", " Next Level...  ", " Next Level...  "};
        vecs[4] = '{3'd6, 4'd12, 16'd1234,  "     Fail...    ", "  Try Again...  ", "  Try Again...  "};
        vecs[5] = '{3'd2, 4'd15, 16'd65535, "Lv. 15          ", "Score: 65535    ", "Score: 9999     "};
        vecs[6] = '{3'd4, 4'd0,  16'd10000, "Lv. 00          ", "Score: 10000    ", "Score: 9999     "};
        vecs[7] = '{3'd4, 4'd9,  16'd9999,  "Lv. 09          ", "Score: 09999    ", "Score: 9999     "};
        vecs[8] = '{3'd7, 4'd9,  16'd10,    "  FINAL SCORE   ", "Total: 00010    ", "Total: 0010     "};

        // Reset and IDLE marquee
        rst = 1'b1; state = 3'd0; current_round = 4'd0; total_score = 16'd0; frame_ready = 1'b1;
        ticks(2);
        chk_line("rst_line_1", line_1, c_BLANK);
        chk_line("rst_line_2", line_2, c_BLANK);
        chk_val("rst_valid", {31'd0, frame_valid}, 32'd0);
        chk_val("rst_busy", {31'd0, bcd_busy}, 32'd0);
        chk_val("rst_valid_d4", {31'd0, frame_valid_d4}, 32'd0);
        rst = 1'b0;
        tick();
        chk_val("first_valid", {31'd0, frame_valid}, 32'd1);
        chk_line("idle_line_1", line_1, "   Game Start   ");
        chk_line("idle_line_2", line_2, "Press Start     ");
        ticks(3);
        chk_line("scroll_1", line_2, "ress Start     P");
        ticks(45);
        chk_line("scroll_wrap", line_2, "Press Start     ");

        // Conversion latency
        state = 3'd3; current_round = 4'd7;
        ticks(2);
        chk_line("lv_line_1", line_1, "Lv. 07          ");
        chk_line("score0_line_2", line_2, "Score: 00000    ");
        total_score = 16'd1234;
        tick();
        chk_val("busy_start", {31'd0, bcd_busy}, 32'd1);
        busy_len(n);
        chk_val("busy_len_1234", n, 32'd16);
        chk_line("score_before_store", line_2, "Score: 00000    ");
        tick();
        chk_line("score_1234", line_2, "Score: 01234    ");
        chk_line("score_1234_d4", line_2_d4, "Score: 1234     ");

        // Score change mid-conversion
        total_score = 16'd123;
        tick();
        ticks(5);
        total_score = 16'd456;
        busy_len(n);
        tick();
        chk_line("score_123", line_2, "Score: 00123    ");
        chk_val("busy_restart", {31'd0, bcd_busy}, 32'd1);
        busy_len(n);
        chk_val("busy_len_456", n, 32'd16);
        tick();
        chk_line("score_456", line_2, "Score: 00456    ");

        // Table-driven screens through a scoreboard
        for (int i = 0; i < 9; i++) begin
            state = vecs[i].st; current_round = vecs[i].rnd; total_score = vecs[i].score;
            sb_q.push_back(vecs[i]);
            tick();
            busy_len(n);
            if (n >= 64) chk_val($sformatf("vec%0d_busy_timeout", i), {31'd0, bcd_busy}, 32'd0);
            tick();
            exp_v = sb_q.pop_front();
            chk_line($sformatf("vec%0d_l1", i), line_1, exp_v.l1);
            chk_line($sformatf("vec%0d_l2", i), line_2, exp_v.l2);
            chk_line($sformatf("vec%0d_l1_d4", i), line_1_d4, exp_v.l1);
            chk_line($sformatf("vec%0d_l2_d4", i), line_2_d4, exp_v.l2d4);
        end

        // FAIL blink then switch to PASS
        state = 3'd6;
        tick();
        chk_line("fail_vis_0", line_1, "     Fail...    ");
        ticks(4);
        chk_line("fail_vis_4", line_1, "     Fail...    ");
        tick();
        chk_line("fail_blank_5", line_1, c_BLANK);
        ticks(3);
        chk_line("fail_blank_8", line_1, c_BLANK);
        chk_line("fail_line_2", line_2, "  Try Again...  ");
        tick();
        chk_line("fail_vis_9", line_1, "     Fail...    ");
        ticks(4);
        chk_line("fail_blank_13", line_1, c_BLANK);
        state = 3'd5;
        tick();
        chk_line("pass_immediate", line_1, "    Success!    ");
        ticks(4);
        chk_line("pass_vis_4", line_1, "    Success!    ");
        tick();
        chk_line("pass_blank_5", line_1, c_BLANK);
        chk_line("pass_line_2", line_2, " Next Level...  ");

        // Back-pressure
        state = 3'd2; current_round = 4'd4;
        ticks(2);
        frame_ready = 1'b0; current_round = 4'd5;
        tick();
        chk_val("bp_valid_load", {31'd0, frame_valid}, 32'd1);
        chk_line("bp_line_1", line_1, "Lv. 05          ");
        state = 3'd5;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (frame_valid !== 1'b1 || line_1 !== "Lv. 05          " ||
                line_2 !== "Score: 00010    ") bad++;
        end
        chk_val("bp_frozen", bad, 32'd0);
        frame_ready = 1'b1;
        tick();
        chk_line("bp_accept_l1", line_1, "    Success!    ");
        chk_line("bp_accept_l2", line_2, " Next Level...  ");
        chk_val("bp_accept_valid", {31'd0, frame_valid}, 32'd1);

        // Reset mid-conversion in DONE
        state = 3'd7; current_round = 4'd0; total_score = 16'd777;
        tick();
        chk_val("done_busy", {31'd0, bcd_busy}, 32'd1);
        ticks(3);
        rst = 1'b1;
        tick();
        chk_line("rst2_line_1", line_1, c_BLANK);
        chk_line("rst2_line_2", line_2, c_BLANK);
        chk_val("rst2_valid", {31'd0, frame_valid}, 32'd0);
        chk_val("rst2_busy", {31'd0, bcd_busy}, 32'd0);
        chk_val("rst2_busy_d4", {31'd0, bcd_busy_d4}, 32'd0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
